// File: rtl/tr_p_pkg.sv
// tr_p_pkg: shared register map, CTRL bit indices, core states and ID constant
package tr_p_pkg;
   localparam logic [3:0]  ADDR_CTRL   = 4'h0;
   localparam logic [3:0]  ADDR_NLEN   = 4'h1;
   localparam logic [3:0]  ADDR_STATUS = 4'h2;
   localparam logic [3:0]  ADDR_COUNT  = 4'h3;
   localparam logic [3:0]  ADDR_ID     = 4'hF;
   localparam int          CTRL_START   = 0;
   localparam int          CTRL_START_N = 1;
   localparam int          CTRL_STOP    = 2;
   localparam logic [31:0] ID_VALUE    = 32'h5452_5001;
   typedef enum logic [1:0] {IDLE, RUN, RUN_N} state_t;
endpackage

// File: rtl/tr_p_core.sv
// tr_p_core: run-control FSM with elapsed-cycle counter and sticky done
module tr_p_core #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          start_n,
   input  logic          stop,
   input  logic          avto,
   input  logic [DW-1:0] nlen,
   output logic          run,
   output logic          mode,
   output logic          done,
   output logic [DW-1:0] count
);
   import tr_p_pkg::*;
   state_t        state, state_n;
   logic [DW-1:0] count_n, nlat, nlat_n;
   logic          done_n;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         nlat  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         nlat  <= nlat_n;
         done  <= done_n;
      end
   end
   // count only advances on cycles that stay in the run state, so an N-run ends at N-1
   always_comb begin
      state_n = state;
      count_n = count;
      nlat_n  = nlat;
      done_n  = done;
      case (state)
         IDLE:
            if (stop) begin
            end else if (start_n) begin
               count_n = '0;
               nlat_n  = nlen;
               done_n  = (nlen == '0);
               state_n = (nlen == '0) ? IDLE : RUN_N;
            end else if (start || avto) begin
               count_n = '0;
               done_n  = 1'b0;
               state_n = RUN;
            end
         RUN:
            if (stop) state_n = IDLE;
            else count_n = (&count) ? count : count + 1'b1;
         RUN_N:
            if (stop) state_n = IDLE;
            else if (count == nlat - 1'b1) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else count_n = count + 1'b1;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      run  = (state == RUN) || (state == RUN_N);
      mode = (state == RUN_N);
   end
endmodule

// File: rtl/tr_p_avalon.sv
// tr_p_avalon: Avalon-MM register file issuing run-control commands to tr_p_core
module tr_p_avalon #(
   parameter int                DW       = 32,
   parameter int                AW       = 4,
   parameter logic [DW-1:0]     ID_VALUE = tr_p_pkg::ID_VALUE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] avs_s0_address,
   input  logic          avs_s0_write,
   input  logic [DW-1:0] avs_s0_writedata,
   input  logic          avs_s0_read,
   output logic [DW-1:0] avs_s0_readdata,
   input  logic          avto,
   output logic          run,
   output logic          done
);
   import tr_p_pkg::*;
   logic          start_p, start_n_p, stop_p, mode, wr_ctrl;
   logic [DW-1:0] nlen, count, status, rdata;
   assign wr_ctrl = avs_s0_write && (avs_s0_address == ADDR_CTRL);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_p         <= 1'b0;
         start_n_p       <= 1'b0;
         stop_p          <= 1'b0;
         nlen            <= '0;
         avs_s0_readdata <= '0;
      end else begin
         start_p   <= wr_ctrl && avs_s0_writedata[CTRL_START];
         start_n_p <= wr_ctrl && avs_s0_writedata[CTRL_START_N];
         stop_p    <= wr_ctrl && avs_s0_writedata[CTRL_STOP];
         if (avs_s0_write && (avs_s0_address == ADDR_NLEN)) nlen <= avs_s0_writedata;
         if (avs_s0_read) avs_s0_readdata <= rdata;
      end
   end
   always_comb begin
      status = {{(DW-3){1'b0}}, done, mode, run};
      rdata  = (avs_s0_address == ADDR_NLEN)   ? nlen     :
               (avs_s0_address == ADDR_STATUS) ? status   :
               (avs_s0_address == ADDR_COUNT)  ? count    :
               (avs_s0_address == ADDR_ID)     ? ID_VALUE : '0;
   end
   tr_p_core #(.DW(DW)) u_core (
      .clk     (clk),
      .rst     (rst),
      .start   (start_p),
      .start_n (start_n_p),
      .stop    (stop_p),
      .avto    (avto),
      .nlen    (nlen),
      .run     (run),
      .mode    (mode),
      .done    (done),
      .count   (count)
   );
endmodule

// File: tb/tb_tr_p_avalon.sv
// tb_tr_p_avalon: directed register-level checks of tr_p_avalon
module tb_tr_p_avalon;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  address = '0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        read = 1'b0;
   logic [31:0] readdata;
   logic        avto = 1'b0;
   logic        run, done;
   logic [31:0] d;
   int          total = 0, bad = 0, run_cyc = 0;
   tr_p_avalon dut (
      .clk              (clk),
      .rst              (rst),
      .avs_s0_address   (address),
      .avs_s0_write     (write),
      .avs_s0_writedata (writedata),
      .avs_s0_read      (read),
      .avs_s0_readdata  (readdata),
      .avto             (avto),
      .run              (run),
      .done             (done)
   );
   always #10 clk = ~clk;
   // counts cycles with run high, sampled just after each rising edge
   always @(posedge clk) begin
      #2;
      if (run === 1'b1) run_cyc++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      @(negedge clk);
      address = a; writedata = v; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask
   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      @(negedge clk);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      v = readdata;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_run", {31'b0, run}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_rdata", readdata, 32'd0);
      rst = 1'b1;
      rd(4'hF, d); check("id", d, 32'h5452_5001);
      rd(4'h7, d); check("unmapped", d, 32'd0);
      run_cyc = 0;
      wr(4'h0, 32'h1);
      check("start_lat_run0", {31'b0, run}, 32'd0);
      @(negedge clk);
      check("start_lat_run1", {31'b0, run}, 32'd1);
      repeat (9) @(negedge clk);
      wr(4'h0, 32'h4);
      repeat (3) @(negedge clk);
      check("free_run_len", run_cyc, 32'd12);
      rd(4'h3, d); check("free_count", d, 32'd11);
      check("free_done", {31'b0, done}, 32'd0);
      rd(4'h2, d); check("free_status", d, 32'd0);
      rd(4'h0, d); check("ctrl_read", d, 32'd0);
      run_cyc = 0;
      wr(4'h1, 32'd5);
      wr(4'h0, 32'h2);
      wr(4'h1, 32'd9);
      repeat (8) @(negedge clk);
      check("nrun_len", run_cyc, 32'd5);
      check("nrun_done", {31'b0, done}, 32'd1);
      rd(4'h2, d); check("nrun_status", d, 32'h4);
      rd(4'h3, d); check("nrun_count", d, 32'd4);
      rd(4'h1, d); check("nlen_rb", d, 32'd9);
      @(negedge clk);
      avto = 1'b1;
      @(negedge clk);
      avto = 1'b0;
      check("avto_run", {31'b0, run}, 32'd1);
      check("avto_done_clr", {31'b0, done}, 32'd0);
      address = 4'h0; writedata = 32'h1; write = 1'b1;
      repeat (2500) @(negedge clk);
      write = 1'b0;
      check("hold_run", {31'b0, run}, 32'd1);
      rd(4'h3, d); check("hold_count_a", d, 32'd2501);
      rd(4'h3, d); check("hold_count_b", d, 32'd2503);
      rd(4'h2, d); check("hold_status", d, 32'h1);
      wr(4'h0, 32'h4);
      repeat (3) @(negedge clk);
      check("hold_stopped", {31'b0, run}, 32'd0);
      run_cyc = 0;
      wr(4'h0, 32'h7);
      repeat (4) @(negedge clk);
      check("stop_wins_run", run_cyc, 32'd0);
      check("stop_wins_done", {31'b0, done}, 32'd0);
      wr(4'h1, 32'd0);
      wr(4'h0, 32'h2);
      repeat (3) @(negedge clk);
      check("n0_done", {31'b0, done}, 32'd1);
      check("n0_run", run_cyc, 32'd0);
      rd(4'h3, d); check("n0_count", d, 32'd0);
      wr(4'h1, 32'd100);
      wr(4'h0, 32'h2);
      repeat (3) @(negedge clk);
      check("abort_pre_run", {31'b0, run}, 32'd1);
      rd(4'h3, d); check("abort_pre_count", d, 32'd3);
      #3 rst = 1'b0;
      #1;
      check("abort_run", {31'b0, run}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_rdata", readdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rd(4'h1, d); check("post_nlen", d, 32'd0);
      rd(4'h3, d); check("post_count", d, 32'd0);
      rd(4'h2, d); check("post_status", d, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tr_p_avalon.md
# tr_p_avalon

Run-control block: an Avalon-MM slave register file (`avs_s0_*`) decodes CPU writes into single-cycle `start`, `start_N` and `stop` command pulses. These drive a run controller core that times either a free-running run or an N-cycle run. An external `avto` pulse can also start a free run. The block sits on the system Avalon interconnect as a peripheral and exports `run`/`done` to the datapath it gates.

## Interface
- `DW`, 32, Avalon data width and counter width.
- `AW`, 4, Avalon word-address width.
- `ID_VALUE`, 32'h5452_5001, constant returned at address 0xF.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; asynchronous, active-low.
- `avs_s0_address`  in  AW  word address.
- `avs_s0_write`  in  1  write strobe, one transfer per cycle high.
- `avs_s0_writedata`  in  DW  write data.
- `avs_s0_read`  in  1  read strobe.
- `avs_s0_readdata`  out  DW  read data, registered.
- `avto`  in  1  auto-start pulse, synchronous to `clk`.
- `run`  out  1  high while a run is active.
- `done`  out  1  sticky; N-run completed.

## Operation
Register map:
- 0x0 CTRL, W. Bit0 = start, bit1 = start_N, bit2 = stop. Each write with a bit set produces a one-cycle pulse on that internal command. Reads return 0.
- 0x1 NLEN, R/W. Run length N for start_N. Reset value 0.
- 0x2 STATUS, R. Bit0 = run, bit1 = mode (1 = N-run), bit2 = done. Other bits 0.
- 0x3 COUNT, R. Elapsed-cycle counter.
- 0xF ID, R. Returns `ID_VALUE`.
- Unmapped addresses read 0; writes to them are ignored.

Core FSM states are IDLE, RUN, RUN_N.
- IDLE to RUN on start or `avto`. COUNT is cleared and done is cleared.
- IDLE to RUN_N on start_N with NLEN ≠ 0. COUNT and done are cleared. NLEN is latched internally; later NLEN writes do not affect the active run.
- start_N with NLEN = 0: stay in IDLE, set done, clear COUNT.
- RUN: COUNT increments each cycle and saturates at all-ones. Stop returns the FSM to IDLE.
- RUN_N: COUNT increments each cycle. When COUNT = N−1, the next state is IDLE and done is set, so `run` is high for exactly N cycles. Stop returns the FSM to IDLE with done unchanged (stays 0).
- start, start_N and `avto` are ignored while in RUN or RUN_N. A held `avs_s0_write` therefore re-issues the command harmlessly.
- Simultaneous commands use the priority stop > start_N > start > `avto`.
- COUNT holds its value in IDLE until the next start.
- `run` is decoded from state (RUN or RUN_N). `done` is registered.

## Timing
- Reset (asynchronous, `rst` low) forces state IDLE, COUNT = 0, NLEN = 0, `run` = 0, `done` = 0, `avs_s0_readdata` = 0, and all command pulses to 0.
- Write in cycle k: the command pulse is registered high in cycle k+1, and `run` rises in cycle k+2. The first COUNT value read back during a run is 0 at cycle k+2.
- `avto` high in cycle k: `run` rises in cycle k+1.
- Read in cycle k: `avs_s0_readdata` is valid in cycle k+1 (fixed latency 1, no waitrequest). It holds its last value when no read is active.
- Stop written in cycle k: `run` falls in cycle k+2.
- Reset asserted mid-run aborts immediately; no done is set.

## Structure
- Shared package `tr_p_pkg` holds:
  - the register address constants (0x0, 0x1, 0x2, 0x3, 0xF);
  - the CTRL bit indices;
  - the FSM state enum {IDLE, RUN, RUN_N};
  - `ID_VALUE`.
- One natural sub-module is `tr_p_core`: the FSM plus counter, with inputs start, start_N, stop, `avto`, nlen. The top level holds the Avalon decode, the registers and the pulse generation.

## Test plan
- Reset with `rst` = 0, then release: all outputs 0, and a read of 0xF returns 32'h5452_5001 one cycle later.
- Write CTRL = 0x1, wait 10 cycles, write CTRL = 0x4: `run` is high for 10 + 2 cycles, and COUNT then reads 11. `done` stays 0.
- Write NLEN = 5, then CTRL = 0x2: `run` is high for exactly 5 cycles, `done` = 1, STATUS reads 0x4, COUNT reads 4.
- Pulse `avto` for one cycle in IDLE: `run` rises the next cycle. Hold `avs_s0_write` with CTRL = 0x1 for 2500 cycles during the run: no restart, and COUNT keeps increasing monotonically.
- Write CTRL = 0x7: stop wins, `run` stays 0. Write NLEN = 0 then CTRL = 0x2: `done` = 1 and `run` never rises.
- Assert `rst` during an N-run: `run` and `done` go to 0 immediately, and reads return reset values.
